serv_rf_ram_if: RTL and testbench

//  Bridge between the bit-serial register-file port of serv_top and a simple-dual-port
//  RAM holding x0-x31 plus CSR-backed registers (index 32+), 2 bits per RAM word.

---
 rtl/serv_rf_ram_if.sv | 136 +++++++++++++
 tb/tb_serv_rf_ram_if.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serv_rf_ram_if.sv
// Bit-serial register-file port to 2-bit-wide simple-dual-port RAM bridge.
// Reads are streamed out LSB first one bit per cycle per operand; writes are packed two bits per RAM word.
module serv_rf_ram_if #(
    parameter  int CSR_REGS = 4,
    localparam int DEPTH    = (32 + CSR_REGS) * 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_rreq,
    input  logic          i_wreq,
    output logic          o_ready,
    input  logic [5:0]    i_rreg0,
    input  logic [5:0]    i_rreg1,
    output logic          o_rdata0,
    output logic          o_rdata1,
    input  logic [5:0]    i_wreg0,
    input  logic [5:0]    i_wreg1,
    input  logic          i_wen0,
    input  logic          i_wen1,
    input  logic          i_wdata0,
    input  logic          i_wdata1,
    output logic [AW-1:0] o_raddr,
    output logic          o_ren,
    input  logic [1:0]    i_rdata,
    output logic [AW-1:0] o_waddr,
    output logic          o_wen,
    output logic [1:0]    o_wdata
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t     state, state_n;
    logic [5:0] cnt;
    logic       rd, wr;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state || state == IDLE) ? 6'd0 : cnt + 6'd1;
        end
    end

    // A read request wins over a simultaneous write request; busy phases ignore both.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (i_rreq)      state_n = RD;
                else if (i_wreq) state_n = WR;
            end
            RD:      if (cnt == 6'd33) state_n = IDLE;
            WR:      if (cnt == 6'd34) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign rd      = (state == RD);
    assign wr      = (state == WR);
    assign o_ready = (rd && cnt == 6'd1) || (wr && cnt == 6'd0);

    // Read slots alternate operand 0 (even) and operand 1 (odd), word index = cnt/2.
    logic [9:0] raddr_full;
    logic [1:0] rd_sr;
    logic       rd_hold;
    logic       rd_bits;

    assign o_ren      = rd && !cnt[5];
    assign raddr_full = {(cnt[0] ? i_rreg1 : i_rreg0), cnt[4:1]};
    assign o_raddr    = o_ren ? AW'(raddr_full) : '0;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            rd_sr   <= 2'b00;
            rd_hold <= 1'b0;
        end else if (rd) begin
            if (cnt[0]) begin
                rd_sr <= i_rdata;
            end else begin
                rd_sr   <= {1'b0, rd_sr[1]};
                rd_hold <= i_rdata[1];
            end
        end
    end

    // Operand 1 data arrives one cycle later than operand 0, so its even bit bypasses straight from the RAM.
    assign rd_bits  = rd && (cnt >= 6'd2);
    assign o_rdata0 = rd_bits && (|i_rreg0) && rd_sr[0];
    assign o_rdata1 = rd_bits && (|i_rreg1) && (cnt[0] ? rd_hold : i_rdata[0]);

    // Write side: even bit lands on odd cnt; port 0 word issues on the next even cnt, port 1 a cycle later.
    logic       wr_lo0, wr_lo1, wr_en0, wr_en1, wr_hen1;
    logic [1:0] wr_hold1;
    logic [3:0] wk;
    logic       p0, p1;

    assign wk = cnt[4:1] - 4'd1;
    assign p0 = wr && !cnt[0] && cnt >= 6'd2 && cnt <= 6'd32;
    assign p1 = wr &&  cnt[0] && cnt >= 6'd3 && cnt <= 6'd33;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wr_lo0   <= 1'b0;
            wr_lo1   <= 1'b0;
            wr_en0   <= 1'b0;
            wr_en1   <= 1'b0;
            wr_hen1  <= 1'b0;
            wr_hold1 <= 2'b00;
            o_wen    <= 1'b0;
            o_waddr  <= '0;
            o_wdata  <= 2'b00;
        end else begin
            o_wen <= (p0 && wr_en0 && (|i_wreg0)) || (p1 && wr_hen1 && (|i_wreg1));
            if (wr && cnt[0]) begin
                wr_lo0 <= i_wdata0;
                wr_lo1 <= i_wdata1;
                wr_en0 <= i_wen0;
                wr_en1 <= i_wen1;
            end
            if (p0) begin
                o_waddr  <= AW'({i_wreg0, wk});
                o_wdata  <= {i_wdata0, wr_lo0};
                wr_hold1 <= {i_wdata1, wr_lo1};
                wr_hen1  <= wr_en1;
            end
            if (p1) begin
                o_waddr <= AW'({i_wreg1, wk});
                o_wdata <= wr_hold1;
            end
        end
    end

endmodule

// File: tb/tb_serv_rf_ram_if.sv
// Scoreboard bench for serv_rf_ram_if: a behavioural RAM backs the DUT, and a reference register image
// supplies expected serial read bits, write addresses/data, and o_ready cycles.
module tb_serv_rf_ram_if;
    localparam int AW = 10;
    localparam int NREG = 36;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_rreq = 1'b0, i_wreq = 1'b0;
    logic          o_ready;
    logic [5:0]    i_rreg0 = '0, i_rreg1 = '0, i_wreg0 = '0, i_wreg1 = '0;
    logic          o_rdata0, o_rdata1;
    logic          i_wen0 = 1'b0, i_wen1 = 1'b0, i_wdata0 = 1'b0, i_wdata1 = 1'b0;
    logic [AW-1:0] o_raddr, o_waddr;
    logic          o_ren, o_wen;
    logic [1:0]    i_rdata;
    logic [1:0]    o_wdata;

    serv_rf_ram_if #(.CSR_REGS(4)) dut (
        .clk(clk), .i_rst(i_rst), .i_rreq(i_rreq), .i_wreq(i_wreq), .o_ready(o_ready),
        .i_rreg0(i_rreg0), .i_rreg1(i_rreg1), .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
        .i_wreg0(i_wreg0), .i_wreg1(i_wreg1), .i_wen0(i_wen0), .i_wen1(i_wen1),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1), .o_raddr(o_raddr), .o_ren(o_ren),
        .i_rdata(i_rdata), .o_waddr(o_waddr), .o_wen(o_wen), .o_wdata(o_wdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read, read data valid the cycle after o_ren.
    logic [1:0] mem [NREG*16];
    logic [1:0] ram_q = 2'b00;
    assign i_rdata = ram_q;
    always @(posedge clk) begin
        if (o_ren) ram_q <= mem[o_raddr];
        if (o_wen) mem[o_waddr] = o_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic [9:0] addr; logic [1:0] data;} wexp_t;
    typedef struct {int cyc; logic d0; logic d1;} rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];
    int    readyq[$];
    logic [31:0] ref_regs [NREG];

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) if (!i_rst) begin
        if (o_ren || o_wen) chk("ren_wen_excl", 32'(o_ren & o_wen), 32'd0);
        if (readyq.size() > 0 && readyq[0] == cyc) begin
            chk("ready", 32'(o_ready), 32'd1);
            readyq.delete(0);
        end else if (o_ready) chk("ready_extra", 32'(o_ready), 32'd0);
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            chk("wen", 32'(o_wen), 32'd1);
            chk("waddr", 32'(o_waddr), 32'(wq[0].addr));
            chk("wdata", 32'(o_wdata), 32'(wq[0].data));
            wq.delete(0);
        end else if (o_wen) chk("wen_extra", 32'(o_wen), 32'd0);
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            chk("rdata0", 32'(o_rdata0), 32'(rq[0].d0));
            chk("rdata1", 32'(o_rdata1), 32'(rq[0].d1));
            rq.delete(0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // abort != 0: assert reset in cycle W+abort and expect only earlier writes to land.
    task automatic do_write(input logic [5:0] r0, input logic [31:0] m0, input logic [31:0] d0,
                            input logic [5:0] r1, input logic [31:0] m1, input logic [31:0] d1,
                            input int abort);
        int w;
        logic [3:0] kk;
        assert (r0 < 6'd36 && r1 < 6'd36) else $error("illegal write register index");
        w = cyc;
        i_wreg0 = r0; i_wreg1 = r1; i_wreq = 1'b1;
        readyq.push_back(w + 1);
        for (int k = 0; k < 16; k++) begin
            kk = 4'(k);
            if (m0[2*k] && r0 != 6'd0 && (abort == 0 || 4 + 2*k < abort)) begin
                wq.push_back('{w + 4 + 2*k, {r0, kk}, d0[2*k +: 2]});
                ref_regs[r0][2*k +: 2] = d0[2*k +: 2];
            end
            if (m1[2*k] && r1 != 6'd0 && (abort == 0 || 5 + 2*k < abort)) begin
                wq.push_back('{w + 5 + 2*k, {r1, kk}, d1[2*k +: 2]});
                ref_regs[r1][2*k +: 2] = d1[2*k +: 2];
            end
        end
        tick();
        i_wreq = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (abort != 0 && cyc == w + abort) begin
                i_rst = 1'b1;
                #1;
                chk("wen_on_reset", 32'(o_wen), 32'd0);
                chk("ready_on_reset", 32'(o_ready), 32'd0);
                tick(); tick();
                i_rst = 1'b0;
                i_wen0 = 1'b0; i_wen1 = 1'b0;
                tick();
                return;
            end
            i_wdata0 = d0[i]; i_wdata1 = d1[i];
            i_wen0 = m0[i];   i_wen1 = m1[i];
        end
        i_wen0 = 1'b0; i_wen1 = 1'b0;
        while (cyc < w + 37) tick();
    endtask

    task automatic do_read(input logic [5:0] r0, input logic [5:0] r1, input int extra, input bit with_wreq);
        int r;
        assert (r0 < 6'd36 && r1 < 6'd36) else $error("illegal read register index");
        r = cyc;
        i_rreg0 = r0; i_rreg1 = r1; i_rreq = 1'b1;
        if (with_wreq) begin
            i_wreq = 1'b1; i_wreg0 = 6'd3; i_wen0 = 1'b1; i_wdata0 = 1'b1;
        end
        readyq.push_back(r + 2);
        for (int i = 0; i < 32; i++)
            rq.push_back('{r + 3 + i, (r0 == 6'd0) ? 1'b0 : ref_regs[r0][i],
                                      (r1 == 6'd0) ? 1'b0 : ref_regs[r1][i]});
        rq.push_back('{r + 35, 1'b0, 1'b0});
        tick();
        i_rreq = 1'b0; i_wreq = 1'b0; i_wen0 = 1'b0; i_wdata0 = 1'b0;
        while (cyc < r + 36) begin
            i_rreq = (extra != 0 && cyc == r + extra);
            tick();
        end
        i_rreq = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            ref_regs[r] = $urandom;
            for (int k = 0; k < 16; k++) mem[r*16 + k] = ref_regs[r][2*k +: 2];
        end
        tick(); tick();
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_ren", 32'(o_ren), 32'd0);
        chk("rst_wen", 32'(o_wen), 32'd0);
        chk("rst_rdata", 32'({o_rdata0, o_rdata1}), 32'd0);
        chk("rst_raddr", 32'(o_raddr), 32'd0);
        chk("rst_waddr", 32'(o_waddr), 32'd0);
        chk("rst_wdata", 32'(o_wdata), 32'd0);
        i_rst = 1'b0;
        tick(); tick();

        do_write(6'd5, '1, 32'hDEADBEEF, 6'd0, '0, '0, 0);
        do_read(6'd5, 6'd0, 0, 1'b0);
        do_write(6'd0, '1, 32'hCAFEF00D, 6'd7, '1, 32'h12345678, 0);
        do_read(6'd5, 6'd7, 0, 1'b0);
        do_write(6'd33, '1, 32'hFFFF0000, 6'd0, '0, '0, 0);
        do_read(6'd33, 6'd5, 0, 1'b0);
        do_write(6'd12, $urandom, $urandom, 6'd13, $urandom, $urandom, 0);
        do_read(6'd12, 6'd13, 0, 1'b0);
        do_write(6'd10, '1, 32'h13579BDF, 6'd11, '1, 32'h2468ACE0, 12);
        do_read(6'd10, 6'd11, 0, 1'b0);
        do_read(6'd7, 6'd33, 10, 1'b0);
        do_read(6'd5, 6'd12, 0, 1'b1);
        do_read(6'd3, 6'd0, 0, 1'b0);
        do_write(6'd9, '1, 32'hA5A5A5A5, 6'd0, '0, '0, 0);
        do_read(6'd9, 6'd9, 0, 1'b0);

        tick(); tick();
        chk("wq_left", 32'(wq.size()), 32'd0);
        chk("rq_left", 32'(rq.size()), 32'd0);
        chk("ready_left", 32'(readyq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
